// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus shared by the boot loader and its host.
// The host side drives the byte stream; the loader side drives the memory write port.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit words
// and writes them into instruction memory, holding the CPU in reset until a good image lands.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    imem_loader_if.slave   bus,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic           hold_cpu
);

    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE} state_t;

    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    state_t      state;
    state_t      next_state;
    logic [1:0]  byte_cnt;
    logic [31:0] shift_word;
    logic [31:0] word_count;
    logic [31:0] word_index;
    logic [31:0] index_next;
    logic [31:0] assembled;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        done_q;
    logic        error_q;
    logic        accept;
    logic        last_byte;
    logic        restart;

    assign bus.rx_ready  = (state == LEN) || (state == DATA);
    assign bus.mem_we    = (state == WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = (state == LEN) || (state == DATA) || (state == WRITE);
    assign done          = done_q;
    assign error         = error_q;
    assign hold_cpu      = !(done_q && !error_q);

    // Bytes shift in from the top so the first byte ends up in bits [7:0].
    assign accept     = bus.rx_ready && bus.rx_valid;
    assign last_byte  = accept && (byte_cnt == 2'd3);
    assign assembled  = {bus.rx_data, shift_word[31:8]};
    assign index_next = word_index + 32'd1;
    assign restart    = ((state == IDLE) || (state == DONE)) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = LEN;
            LEN: begin
                if (last_byte) begin
                    if ((assembled == 32'd0) || (assembled > DEPTH_LIMIT)) begin
                        next_state = DONE;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA:  if (last_byte) next_state = WRITE;
            WRITE: next_state = (index_next == word_count) ? DONE : DATA;
            DONE:  if (start) next_state = LEN;
            default: next_state = IDLE;
        endcase
    end

    // Address and data are captured as the word completes so they are stable for the whole WRITE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= 2'd0;
            shift_word <= 32'd0;
            word_count <= 32'd0;
            word_index <= 32'd0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            if (restart) begin
                byte_cnt <= 2'd0;
                done_q   <= 1'b0;
                error_q  <= 1'b0;
            end
            if (accept) begin
                shift_word <= assembled;
                byte_cnt   <= byte_cnt + 2'd1;
            end
            if ((state == LEN) && last_byte) begin
                word_count <= assembled;
                word_index <= 32'd0;
                if (assembled == 32'd0) begin
                    done_q <= 1'b1;
                end else if (assembled > DEPTH_LIMIT) begin
                    done_q  <= 1'b1;
                    error_q <= 1'b1;
                end
            end
            if ((state == DATA) && last_byte) begin
                addr_q  <= BASE_ADDR + (word_index << 2);
                wdata_q <= assembled;
            end
            if (state == WRITE) begin
                word_index <= index_next;
                if (index_next == word_count) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams hand-built images and checks every memory write
// and status output against hand-computed values.
module tb_imem_loader;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic error;
    logic hold_cpu;

    int assert_count = 0;
    int fail_count   = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] img_words[$];

    imem_loader_if bus ();

    imem_loader #(
        .BASE_ADDR  (32'h0000_0000),
        .DEPTH_WORDS(256)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus.slave),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .hold_cpu(hold_cpu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Record every write strobe; the loader must never take bytes or drop busy while writing.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
            checkOutput("rx_ready_in_write", {31'd0, bus.rx_ready}, 32'd0);
            checkOutput("busy_in_write", {31'd0, busy}, 32'd1);
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input bit gapped);
        int waited;
        int idle;
        waited = 0;
        if (gapped) begin
            idle = int'($urandom_range(0, 3));
            bus.rx_valid = 1'b0;
            repeat (idle) begin
                @(posedge clk);
                #1;
            end
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 100) checkOutput("rx_ready_wait", {31'd0, bus.rx_ready}, 32'd1);
        @(posedge clk);
        #1;
        if (gapped && ($urandom_range(0, 1) == 1)) bus.rx_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input bit gapped);
        for (int i = 0; i < 4; i++) applyStimulus(w[8*i +: 8], gapped);
    endtask

    task automatic sendImage(input logic [31:0] n, input bit gapped);
        sendWord(n, gapped);
        foreach (img_words[i]) sendWord(img_words[i], gapped);
        bus.rx_valid = 1'b0;
    endtask

    task automatic startSession();
        wr_addr.delete();
        wr_data.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, {31'd0, done}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkWrites(input string tag);
        checkOutput({tag, "_count"}, 32'(wr_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), wr_addr[i], exp_addr[i]);
            checkOutput($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data[i]);
        end
    endtask

    task automatic expectImage();
        exp_addr.delete();
        exp_data.delete();
        foreach (img_words[i]) begin
            exp_addr.push_back(32'(i) * 32'd4);
            exp_data.push_back(img_words[i]);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        #1;
        checkOutput("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'h0000_0000);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0000_0000);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_error", {31'd0, error}, 32'd0);
        checkOutput("rst_hold", {31'd0, hold_cpu}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] basic two-word load");
        startSession();
        checkOutput("basic_busy", {31'd0, busy}, 32'd1);
        checkOutput("basic_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        sendWord(32'd2, 1'b0);
        sendWord(32'h0000_0013, 1'b0);
        checkOutput("basic_we0", {31'd0, bus.mem_we}, 32'd1);
        checkOutput("basic_addr0", bus.mem_addr, 32'h0000_0000);
        checkOutput("basic_data0", bus.mem_wdata, 32'h0000_0013);
        sendWord(32'h0040_0093, 1'b0);
        checkOutput("basic_we1", {31'd0, bus.mem_we}, 32'd1);
        checkOutput("basic_addr1", bus.mem_addr, 32'h0000_0004);
        checkOutput("basic_data1", bus.mem_wdata, 32'h0040_0093);
        checkOutput("basic_done_early", {31'd0, done}, 32'd0);
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("basic_we_after", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("basic_done", {31'd0, done}, 32'd1);
        checkOutput("basic_error", {31'd0, error}, 32'd0);
        checkOutput("basic_hold", {31'd0, hold_cpu}, 32'd0);
        checkOutput("basic_busy_end", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        exp_addr = '{32'h0, 32'h4};
        exp_data = '{32'h0000_0013, 32'h0040_0093};
        checkWrites("basic");

        $display("[TB] gapped five-word load with ignored start");
        img_words = '{32'h0000_0013, 32'h0040_0093, 32'h00C0_0113, 32'h0020_81B3, 32'h0031_2023};
        expectImage();
        startSession();
        sendWord(32'd5, 1'b1);
        sendWord(img_words[0], 1'b1);
        bus.rx_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("gap_busy_after_start", {31'd0, busy}, 32'd1);
        checkOutput("gap_ready_after_start", {31'd0, bus.rx_ready}, 32'd1);
        for (int i = 1; i < 5; i++) sendWord(img_words[i], 1'b1);
        bus.rx_valid = 1'b0;
        waitDone("gap_done");
        checkOutput("gap_error", {31'd0, error}, 32'd0);
        checkWrites("gap");

        $display("[TB] zero-length image");
        startSession();
        sendWord(32'd0, 1'b0);
        bus.rx_valid = 1'b0;
        checkOutput("n0_done", {31'd0, done}, 32'd1);
        checkOutput("n0_error", {31'd0, error}, 32'd0);
        checkOutput("n0_hold", {31'd0, hold_cpu}, 32'd0);
        checkOutput("n0_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("n0_count", 32'(wr_addr.size()), 32'd0);

        $display("[TB] full-depth image");
        img_words.delete();
        for (int i = 0; i < 256; i++) img_words.push_back(32'h5A00_0000 + 32'(i));
        expectImage();
        startSession();
        sendImage(32'd256, 1'b0);
        waitDone("full_done");
        checkOutput("full_error", {31'd0, error}, 32'd0);
        checkOutput("full_last_addr", wr_addr[$], 32'h0000_03FC);
        checkWrites("full");

        $display("[TB] oversize image");
        startSession();
        sendWord(32'd257, 1'b0);
        checkOutput("big_done", {31'd0, done}, 32'd1);
        checkOutput("big_error", {31'd0, error}, 32'd1);
        checkOutput("big_hold", {31'd0, hold_cpu}, 32'd1);
        checkOutput("big_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        bus.rx_data = 8'h13;
        repeat (4) @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        checkOutput("big_count", 32'(wr_addr.size()), 32'd0);

        $display("[TB] restart after error with one-word image");
        img_words = '{32'h0000_8067};
        expectImage();
        startSession();
        checkOutput("re_done_clear", {31'd0, done}, 32'd0);
        checkOutput("re_error_clear", {31'd0, error}, 32'd0);
        checkOutput("re_busy", {31'd0, busy}, 32'd1);
        checkOutput("re_hold", {31'd0, hold_cpu}, 32'd1);
        sendImage(32'd1, 1'b0);
        waitDone("re_done");
        checkOutput("re_error", {31'd0, error}, 32'd0);
        checkOutput("re_hold_end", {31'd0, hold_cpu}, 32'd0);
        checkWrites("re");

        $display("[TB] reset in the middle of a word");
        startSession();
        sendWord(32'd2, 1'b0);
        sendWord(32'hDEAD_BEEF, 1'b0);
        applyStimulus(8'h78, 1'b0);
        applyStimulus(8'h56, 1'b0);
        rst = 1'b1;
        #1;
        bus.rx_valid = 1'b0;
        checkOutput("mid_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        checkOutput("mid_mem_we", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("mid_mem_addr", bus.mem_addr, 32'h0000_0000);
        checkOutput("mid_mem_wdata", bus.mem_wdata, 32'h0000_0000);
        checkOutput("mid_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_done", {31'd0, done}, 32'd0);
        checkOutput("mid_hold", {31'd0, hold_cpu}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid_count", 32'(wr_addr.size()), 32'd1);
        checkOutput("mid_word0", wr_data[0], 32'hDEAD_BEEF);
        img_words = '{32'hCAFE_F00D, 32'h0BAD_C0DE};
        expectImage();
        @(posedge clk);
        #1;
        startSession();
        sendImage(32'd2, 1'b0);
        waitDone("reload_done");
        checkOutput("reload_error", {31'd0, error}, 32'd0);
        checkOutput("reload_hold", {31'd0, hold_cpu}, 32'd0);
        checkWrites("reload");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
